// File: rtl/lsu_misalign.sv
// lsu_misalign: MEM-stage load/store initiator splitting misaligned accesses into byte-serial transfers; define DIAGV2_MISALIGN_TRAP_EN to flag them instead
`ifndef DataBusBits
`define DataBusBits 63:0
`endif
`ifndef MemTypeBusBits
`define MemTypeBusBits 2:0
`endif
`ifndef DataZero
`define DataZero 64'h0
`endif
`ifndef MemTypeB
`define MemTypeB 3'd0
`define MemTypeH 3'd1
`define MemTypeW 3'd2
`define MemTypeD 3'd3
`define MemTypeBU 3'd4
`define MemTypeHU 3'd5
`define MemTypeWU 3'd6
`endif
module lsu_misalign #(
  parameter int BYTE_IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [`MemTypeBusBits]  req_memType,
  input  logic [`DataBusBits]     req_addr,
  input  logic [`DataBusBits]     req_wd,
  output logic                    stall,
  output logic                    ld_valid,
  output logic [`DataBusBits]     ld_data,
  output logic                    misalign,
  output logic                    mem_we,
  output logic [`MemTypeBusBits]  mem_memType,
  output logic [`DataBusBits]     mem_addr,
  output logic [`DataBusBits]     mem_wd,
  input  logic [`DataBusBits]     mem_rd
);
  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;
  state_t                 state_q, state_d;
  logic [BYTE_IDX_W-1:0]  cnt_q, cnt_d;
  logic [`DataBusBits]    buf_q, buf_d, addr_q, addr_d, wd_q, wd_d;
  logic                   we_q, we_d;
  logic [`MemTypeBusBits] mt_q, mt_d;
  logic [3:0]             n_q, n_d, req_n;
  logic [2:0]             amask;
  logic                   req_ok, req_mis;
  logic [6:0]             sh;
  logic signed [63:0]     ld_sx;
  logic [63:0]            ld_zx;
  // access size and alignment of the live request; size 0 marks an unknown type
  always_comb begin
    req_n = (req_memType == `MemTypeB || req_memType == `MemTypeBU) ? 4'd1 :
            (req_memType == `MemTypeH || req_memType == `MemTypeHU) ? 4'd2 :
            (req_memType == `MemTypeW || req_memType == `MemTypeWU) ? 4'd4 :
            (req_memType == `MemTypeD) ? 4'd8 : 4'd0;
    req_ok = req_n != 4'd0;
    amask = req_n[2:0] - 3'd1;
    req_mis = req_ok && ((req_addr[2:0] & amask) != 3'd0);
  end
  // reassembled bytes are pushed to the top then shifted back to extend
  assign sh = 7'd64 - {n_q, 3'b000};
  assign ld_sx = $signed(buf_q << sh) >>> sh;
  assign ld_zx = (buf_q << sh) >> sh;
  // next-state and combinational memory-port/pipeline outputs
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    addr_d = addr_q;
    wd_d = wd_q;
    we_d = we_q;
    mt_d = mt_q;
    n_d = n_q;
    stall = 1'b0;
    ld_valid = 1'b0;
    ld_data = `DataZero;
    misalign = 1'b0;
    mem_we = 1'b0;
    mem_memType = '0;
    mem_addr = '0;
    mem_wd = '0;
    if (state_q == IDLE && req_valid && req_ok && !req_mis) begin
      mem_we = req_we;
      mem_memType = req_memType;
      mem_addr = req_addr;
      mem_wd = req_wd;
      ld_data = mem_rd;
      ld_valid = ~req_we;
    end else if (state_q == IDLE && req_valid && req_mis) begin
`ifdef DIAGV2_MISALIGN_TRAP_EN
      misalign = 1'b1;
`else
      stall = 1'b1;
      we_d = req_we;
      mt_d = req_memType;
      addr_d = req_addr;
      wd_d = req_wd;
      n_d = req_n;
      cnt_d = '0;
      state_d = SPLIT;
`endif
    end else if (state_q == SPLIT) begin
      stall = 1'b1;
      mem_addr = addr_q + 64'(cnt_q);
      mem_we = we_q;
      mem_memType = we_q ? `MemTypeB : `MemTypeBU;
      mem_wd = we_q ? {56'd0, wd_q[8*cnt_q +: 8]} : '0;
      if (!we_q) buf_d[8*cnt_q +: 8] = mem_rd[7:0];
      state_d = (cnt_q == BYTE_IDX_W'(n_q - 4'd1)) ? DONE : SPLIT;
      cnt_d = (cnt_q == BYTE_IDX_W'(n_q - 4'd1)) ? cnt_q : cnt_q + 1'b1;
    end else if (state_q == DONE) begin
      ld_valid = ~we_q;
      ld_data = we_q ? `DataZero :
                (mt_q == `MemTypeH || mt_q == `MemTypeW) ? 64'(ld_sx) : ld_zx;
      state_d = IDLE;
    end
  end
  // state, byte counter, reassembly buffer and latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      buf_q <= '0;
      addr_q <= '0;
      wd_q <= '0;
      we_q <= 1'b0;
      mt_q <= '0;
      n_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
      we_q <= we_d;
      mt_q <= mt_d;
      n_q <= n_d;
    end
  end
endmodule

// File: tb/tb_lsu_misalign.sv
// tb_lsu_misalign: randomized self-checking bench for lsu_misalign against a byte-array reference model
`ifndef DataBusBits
`define DataBusBits 63:0
`endif
`ifndef MemTypeBusBits
`define MemTypeBusBits 2:0
`endif
`ifndef DataZero
`define DataZero 64'h0
`endif
`ifndef MemTypeB
`define MemTypeB 3'd0
`define MemTypeH 3'd1
`define MemTypeW 3'd2
`define MemTypeD 3'd3
`define MemTypeBU 3'd4
`define MemTypeHU 3'd5
`define MemTypeWU 3'd6
`endif
module tb_lsu_misalign;
  logic clk, rst, mem_clr;
  logic req_valid, req_we;
  logic [2:0] req_memType, mem_memType;
  logic [63:0] req_addr, req_wd, ld_data, mem_addr, mem_wd, mem_rd;
  logic stall, ld_valid, misalign, mem_we;
  int checks = 0;
  int failures = 0;
  logic [7:0] dmem [0:4095];
  logic [7:0] refm [0:4095];

  lsu_misalign #(.BYTE_IDX_W(3)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_we(req_we),
    .req_memType(req_memType), .req_addr(req_addr), .req_wd(req_wd),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .misalign(misalign),
    .mem_we(mem_we), .mem_memType(mem_memType), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sz(input logic [2:0] mt);
    case (mt)
      `MemTypeB, `MemTypeBU: return 1;
      `MemTypeH, `MemTypeHU: return 2;
      `MemTypeW, `MemTypeWU: return 4;
      `MemTypeD: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] ext(input logic [2:0] mt, input logic [63:0] raw);
    int n;
    logic [63:0] mask, r;
    n = sz(mt);
    if (n == 0) return 64'd0;
    if (n == 8) return raw;
    mask = (64'd1 << (8 * n)) - 64'd1;
    r = raw & mask;
    if ((mt == `MemTypeB || mt == `MemTypeH || mt == `MemTypeW) && ((r >> (8 * n - 1)) & 64'd1) == 64'd1)
      r = r | ~mask;
    return r;
  endfunction

  // data memory environment: combinational read, write on the clock edge
  always_comb begin
    logic [63:0] raw;
    raw = 64'd0;
    for (int k = 0; k < 8; k++)
      if (k < sz(mem_memType)) raw = raw | (64'(dmem[12'(mem_addr + 64'(k))]) << (8 * k));
    mem_rd = ext(mem_memType, raw);
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= 8'd0;
    end else if (mem_we) begin
      for (int k = 0; k < 8; k++)
        if (k < sz(mem_memType)) dmem[12'(mem_addr + 64'(k))] <= mem_wd[8*k +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one access through the DUT, checked against the reference byte array
  task automatic access(input logic we, input logic [2:0] mt, input logic [63:0] a, input logic [63:0] wd);
    int n, cyc;
    logic [63:0] raw, exp;
    bit mis, wr;
    n = sz(mt);
    raw = 64'd0;
    for (int k = 0; k < n; k++) raw = raw | (64'(refm[12'(a + 64'(k))]) << (8 * k));
    exp = ext(mt, raw);
    mis = (n > 1) && ((a % 64'(n)) != 64'd0);
    wr = we && n > 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_memType = mt; req_addr = a; req_wd = wd;
    #1;
    if (n == 0) begin
      check("nop_stall", 64'(stall), 64'd0);
      check("nop_we", 64'(mem_we), 64'd0);
      check("nop_ldv", 64'(ld_valid), 64'd0);
      check("nop_ld", ld_data, 64'd0);
    end else if (!mis) begin
      check("al_stall", 64'(stall), 64'd0);
      check("al_addr", mem_addr, a);
      check("al_we", 64'(mem_we), 64'(we));
      check("al_mis", 64'(misalign), 64'd0);
      check("al_ldv", 64'(ld_valid), 64'(!we));
      if (!we) check("al_ld", ld_data, exp);
    end else begin
`ifdef DIAGV2_MISALIGN_TRAP_EN
      check("trap_mis", 64'(misalign), 64'd1);
      check("trap_stall", 64'(stall), 64'd0);
      check("trap_we", 64'(mem_we), 64'd0);
      check("trap_ldv", 64'(ld_valid), 64'd0);
      wr = 1'b0;
`else
      cyc = 0;
      while (stall === 1'b1 && cyc < 20) begin
        if (cyc == 0) check("sp_latch_we", 64'(mem_we), 64'd0);
        else begin
          check("sp_addr", mem_addr, a + 64'(cyc - 1));
          check("sp_we", 64'(mem_we), 64'(we));
          if (we) check("sp_wd", mem_wd, (wd >> (8 * (cyc - 1))) & 64'hFF);
        end
        cyc++;
        @(negedge clk);
        #1;
      end
      check("sp_len", 64'(cyc), 64'(n + 1));
      check("done_we", 64'(mem_we), 64'd0);
      check("done_ldv", 64'(ld_valid), 64'(!we));
      if (!we) check("done_ld", ld_data, exp);
`endif
    end
    if (wr) for (int k = 0; k < n; k++) refm[12'(a + 64'(k))] = wd[8*k +: 8];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [7:0] b23;
    logic [7:0] t2 [4];
    for (int i = 0; i < 4096; i++) refm[i] = 8'd0;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_memType = 3'd0; req_addr = 64'd0; req_wd = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_ldv", 64'(ld_valid), 64'd0);
    check("rst_ld", ld_data, 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", mem_addr, 64'd0);

    // aligned doubleword load
    for (int k = 0; k < 8; k++) access(1'b1, `MemTypeB, 64'h10 + 64'(k), 64'(8'h88 - 8'(k * 8'h11)));
    access(1'b0, `MemTypeD, 64'h10, 64'd0);
    check("t1_ld", ld_data, 64'h1122334455667788);
    check("t1_type", 64'(mem_memType), 64'(`MemTypeD));

    // misaligned word store then byte readback
    access(1'b1, `MemTypeW, 64'h0F, 64'h12345678);
    t2[0] = 8'h78; t2[1] = 8'h56; t2[2] = 8'h34; t2[3] = 8'h12;
    for (int k = 0; k < 4; k++) begin
      access(1'b0, `MemTypeBU, 64'h0F + 64'(k), 64'd0);
`ifndef DIAGV2_MISALIGN_TRAP_EN
      check("t2_byte", ld_data, 64'(t2[k]));
`endif
    end

    // misaligned halfword load, signed and unsigned
    access(1'b1, `MemTypeB, 64'h07, 64'h80);
    access(1'b1, `MemTypeB, 64'h08, 64'hFF);
    access(1'b0, `MemTypeH, 64'h07, 64'd0);
`ifndef DIAGV2_MISALIGN_TRAP_EN
    check("t3_lh", ld_data, 64'hFFFFFFFFFFFFFF80);
`endif
    access(1'b0, `MemTypeHU, 64'h07, 64'd0);
`ifndef DIAGV2_MISALIGN_TRAP_EN
    check("t3_lhu", ld_data, 64'h000000000000FF80);
`endif

    // doubleword load crossing a line boundary
    for (int k = 0; k < 8; k++) access(1'b1, `MemTypeB, 64'h7FD + 64'(k), 64'(k + 1));
    access(1'b0, `MemTypeD, 64'h7FD, 64'd0);
`ifndef DIAGV2_MISALIGN_TRAP_EN
    check("t4_ld", ld_data, 64'h0807060504030201);
`endif
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("t4_ldv_once", 64'(ld_valid), 64'd0);

`ifndef DIAGV2_MISALIGN_TRAP_EN
    // reset in the middle of a split store
    b23 = refm[12'h23];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_memType = `MemTypeD; req_addr = 64'h21; req_wd = 64'hAABBCCDDEEFF0011;
    #1;
    check("t5_latch", 64'(stall), 64'd1);
    @(negedge clk); #1;
    check("t5_b0", mem_addr, 64'h21);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_b1", mem_addr, 64'h22);
    check("t5_wd1", mem_wd, 64'h00);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("t5_stall", 64'(stall), 64'd0);
    check("t5_m21", 64'(dmem[12'h21]), 64'h11);
    check("t5_m22", 64'(dmem[12'h22]), 64'h00);
    check("t5_m23", 64'(dmem[12'h23]), 64'(b23));
    refm[12'h21] = 8'h11;
    refm[12'h22] = 8'h00;
`else
    access(1'b0, `MemTypeW, 64'h02, 64'd0);
    access(1'b0, `MemTypeW, 64'h04, 64'd0);
`endif

    // randomized mix including unknown memory types
    for (int i = 0; i < 200; i++)
      access(1'($urandom % 2), 3'($urandom_range(0, 7)), 64'($urandom_range(0, 4080)), {$urandom, $urandom});
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (dmem[i] !== refm[i]) bad++;
    check("mem_final", 64'(bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_misalign.md
Name: lsu_misalign

Overview:
- Load/store initiator in the MEM stage of the pipelined core; drives the data memory port (we, memType, addr, wd; combinational rd; write on clk edge).
- Naturally aligned accesses pass straight through in one cycle with no stall.
- Misaligned halfword, word and doubleword accesses are split into byte-serial accesses. The pipeline is stalled while the split runs; load bytes are reassembled and sign- or zero-extended.

Parameters:
- BYTE_IDX_W, 3, width of byte counter (max 8 bytes per access).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  MEM-stage instruction is a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_memType  in  `MemTypeBusBits  access type (`MemTypeB/H/W/D/BU/HU/WU).
- req_addr  in  `DataBusBits  byte address.
- req_wd  in  `DataBusBits  store data, right-aligned.
- stall  out  1  hold pipeline; request inputs stay stable while high.
- ld_valid  out  1  ld_data valid this cycle.
- ld_data  out  `DataBusBits  extended load result.
- misalign  out  1  misaligned-access flag (see Optional Feature).
- mem_we  out  1  to data memory.
- mem_memType  out  `MemTypeBusBits  to data memory.
- mem_addr  out  `DataBusBits  to data memory.
- mem_wd  out  `DataBusBits  to data memory.
- mem_rd  in  `DataBusBits  from data memory, combinational.

Behaviour:
- Size N: B/BU=1, H/HU=2, W/WU=4, D=8. Aligned means addr mod N == 0. B/BU are always aligned.
- Unknown memType with req_valid=1 is a no-op: mem_we=0, ld_valid=0, ld_data=`DataZero, stall=0.
- States: IDLE, SPLIT, DONE. Reset: state IDLE, counter 0, byte buffer 0, latched request 0.
- Outputs are combinational from state and inputs. With req_valid=0 in IDLE, every output is 0.
- IDLE, aligned request:
  - mem_* = req_* passthrough; stall=0.
  - ld_data = mem_rd; ld_valid = ~req_we.
  - Latency 0; the store commits at the clock edge.
- IDLE, misaligned request:
  - stall=1; mem_we=0.
  - Latch we, memType, addr, wd, N; counter<=0; go to SPLIT.
- SPLIT, counter i:
  - stall=1; mem_addr = latched addr + i (64-bit, wraps modulo 2^64).
  - Store: mem_memType=`MemTypeB, mem_we=1, mem_wd[7:0] = wd[8i+7:8i], upper bits 0.
  - Load: mem_memType=`MemTypeBU, mem_we=0; buffer[8i+7:8i] <= mem_rd[7:0].
  - i==N-1: go to DONE; otherwise i<=i+1.
- DONE (one cycle):
  - stall=0; mem_we=0; no memory access.
  - Load: ld_valid=1; ld_data = buffer[8N-1:0] sign-extended from bit 8N-1 for H/W, zero-extended for HU/WU, raw 64 bits for D.
  - Store: ld_valid=0.
  - The live request is ignored; the pipeline advances at this edge. Next state IDLE.
- Stall duration for a misaligned access: N+1 cycles (1 latch + N bytes), then 1 DONE cycle.
- Reset mid-SPLIT: at the next edge go to IDLE, clear counter and buffer; stall=0 the following cycle. Bytes already stored stay in memory.
- Line-crossing accesses (e.g. addr 0x7FD, N=8) need no special handling; byte addresses are simply consecutive.

Optional Feature:
- Macro DIAGV2_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request in IDLE does not split: misalign=1 that cycle, mem_we=0, ld_valid=0, stall=0.
  - SPLIT and DONE are unreachable.
- Undefined: split behaviour as above; misalign is tied to 0.

Test Plan:
1. Aligned LD at 0x10 (dmem line 2 = 0x1122334455667788) -> same cycle: mem_memType=`MemTypeD, ld_valid=1, ld_data=0x1122334455667788, stall=0 throughout.
2. Misaligned SW of 0x12345678 at 0x0F -> stall high 5 cycles; byte writes 0x78@0x0F, 0x56@0x10, 0x34@0x11, 0x12@0x12; then aligned LBU of each byte returns those values.
3. LH at 0x07, bytes 0x07=0x80, 0x08=0xFF -> stall 3 cycles, DONE ld_data=0xFFFFFFFFFFFFFF80; same with LHU -> 0x000000000000FF80.
4. LD at 0x7FD over bytes 0x01..0x08 -> 8 byte reads at 0x7FD..0x804, stall 9 cycles, ld_data=0x0807060504030201, ld_valid high exactly 1 cycle.
5. Misaligned SD of 0xAABBCCDDEEFF0011 at 0x21; reset asserted after 2 byte writes -> IDLE next edge, stall=0; only 0x11@0x21 and 0x00@0x22 written, 0x23 unchanged.
6. With DIAGV2_MISALIGN_TRAP_EN: LW at 0x02 -> misalign=1 for 1 cycle, mem_we=0, stall=0, ld_valid=0; aligned LW at 0x04 is unaffected.
